dmem_ctrl: RTL and testbench

Data-memory access controller between the execute stage and the load/store writeback register stage. Takes a load or store from execute and computes the effective address. Drives a request/ready handshake to data memory with byte enables and lane-replicated store data. Returns sign- or zero-extended load data to the downstream stage, stalling the pipeline until the access completes.

---
 rtl/dmem_ctrl_pkg.sv | 22 ++
 rtl/dmem_align.sv | 48 ++++
 rtl/dmem_ctrl.sv | 135 +++++++++++++
 tb/tb_dmem_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared core constants for load/store decoding in the data-memory path.
package dmem_ctrl_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants only exist for loads.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !is_store;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering: store enables/replication, load extraction/extension, misalignment.
module dmem_align
  import dmem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  ea_lo,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b    = rdata[{ea_lo, 3'b000} +: 8];
    lane_h    = ea_lo[1] ? rdata[31:16] : rdata[15:0];
    be        = 4'b1111;
    wdata     = rs2;
    misalign  = 1'b0;
    rdata_ext = rdata;

    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << ea_lo;
        wdata = {4{rs2[7:0]}};
      end
      2'b01: begin
        be       = 4'b0011 << ea_lo;
        wdata    = {2{rs2[15:0]}};
        misalign = ea_lo[0];
      end
      default: misalign = |ea_lo;
    endcase

    case (funct3)
      F3_B:    rdata_ext = {{24{lane_b[7]}}, lane_b};
      F3_BU:   rdata_ext = {24'b0, lane_b};
      F3_H:    rdata_ext = {{16{lane_h[15]}}, lane_h};
      F3_HU:   rdata_ext = {16'b0, lane_h};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store controller: effective address, memory request handshake, pipeline stall.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int PC_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [6:0]           ex_opcode,
  input  logic [2:0]           ex_funct3,
  input  logic [REG_WIDTH-1:0] ex_rs1,
  input  logic [REG_WIDTH-1:0] ex_immVal,
  input  logic [REG_WIDTH-1:0] ex_rs2,
  input  logic [REG_WIDTH-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [3:0]           mem_be,
  output logic [PC_WIDTH-1:0]  mem_adr,
  output logic [REG_WIDTH-1:0] mem_wdata,
  output logic [REG_WIDTH-1:0] dmem_rdata,
  output logic                 dmem_stall,
  output logic                 dmem_fault
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t state_q, state_d;

  logic [REG_WIDTH-1:0] ea_sum;
  logic [PC_WIDTH-1:0]  ea;
  logic                 is_load, is_store, is_mem, fault_now;
  logic [2:0]           f3_q, al_f3;
  logic [1:0]           off_q, al_off;
  logic                 fault_q;
  logic [3:0]           al_be;
  logic [31:0]          al_wdata, al_rdata;
  logic                 al_misalign;

  assign ea_sum   = ex_rs1 + ex_immVal;
  assign ea       = ea_sum[PC_WIDTH-1:0];
  assign is_load  = (ex_opcode == OP_LOAD);
  assign is_store = (ex_opcode == OP_STORE);
  assign is_mem   = is_load || is_store;

  // The aligner is shared: it sees live execute fields in IDLE and the
  // latched funct3/offset afterwards, so load extension uses stable values.
  assign al_f3  = (state_q == IDLE) ? ex_funct3 : f3_q;
  assign al_off = (state_q == IDLE) ? ea[1:0]   : off_q;

  dmem_align u_align (
    .funct3    (al_f3),
    .ea_lo     (al_off),
    .rs2       (ex_rs2),
    .rdata     (mem_rdata),
    .be        (al_be),
    .wdata     (al_wdata),
    .rdata_ext (al_rdata),
    .misalign  (al_misalign)
  );

  assign fault_now = !f3_legal(is_store, ex_funct3) || al_misalign;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    dmem_stall = 1'b0;
    dmem_fault = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mem) begin
          dmem_stall = 1'b1;
          state_d    = fault_now ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        dmem_stall = 1'b1;
        if (mem_ready) state_d = DONE;
      end
      DONE: begin
        dmem_fault = fault_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_adr    <= '0;
      mem_wdata  <= '0;
      dmem_rdata <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_mem) begin
            if (fault_now) begin
              fault_q    <= 1'b1;
              dmem_rdata <= '0;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_be    <= is_store ? al_be : 4'b1111;
              mem_adr   <= {ea[PC_WIDTH-1:2], 2'b00};
              mem_wdata <= is_store ? al_wdata : '0;
              f3_q      <= ex_funct3;
              off_q     <= ea[1:0];
              fault_q   <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) dmem_rdata <= al_rdata;
          end
        end
        DONE: fault_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed vector bench for dmem_ctrl with a small ready-driving memory responder.
module tb_dmem_ctrl;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] ADD   = 7'b0110011;
  localparam logic [6:0] NOP   = 7'b0010011;

  logic        clk, resetn;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1, ex_immVal, ex_rs2, mem_rdata;
  logic        mem_ready;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_adr, mem_wdata, dmem_rdata;
  logic        dmem_stall, dmem_fault;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  dmem_ctrl #(.REG_WIDTH(32), .PC_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_rs1(ex_rs1), .ex_immVal(ex_immVal), .ex_rs2(ex_rs2),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_stall(dmem_stall), .dmem_fault(dmem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] rs1, imm, rs2, rdata;
    int unsigned k;
    logic        exp_req, exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_adr, exp_wdata, exp_rd;
    logic        exp_fault;
    int unsigned exp_stall;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input string nm, input logic [6:0] op, input logic [2:0] f3,
                              input logic [31:0] rs1, input logic [31:0] imm,
                              input logic [31:0] rs2, input logic [31:0] rdata,
                              input int unsigned k, input logic req, input logic we,
                              input logic [3:0] be, input logic [31:0] adr,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input logic flt, input int unsigned stl);
    vec_t v;
    v.name = nm; v.op = op; v.f3 = f3; v.rs1 = rs1; v.imm = imm; v.rs2 = rs2;
    v.rdata = rdata; v.k = k; v.exp_req = req; v.exp_we = we; v.exp_be = be;
    v.exp_adr = adr; v.exp_wdata = wd; v.exp_rd = rd; v.exp_fault = flt;
    v.exp_stall = stl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned stall_n = 0;
    int unsigned acc = 0;
    bit req_seen = 0;
    bit done = 0;
    @(negedge clk);
    ex_opcode = v.op; ex_funct3 = v.f3; ex_rs1 = v.rs1; ex_immVal = v.imm; ex_rs2 = v.rs2;
    mem_ready = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (dmem_stall) begin
        stall_n++;
        if (mem_req) begin
          acc++;
          req_seen = 1;
          if (acc == 1) begin
            chk({v.name, " we"},  {31'b0, mem_we}, {31'b0, v.exp_we});
            chk({v.name, " be"},  {28'b0, mem_be}, {28'b0, v.exp_be});
            chk({v.name, " adr"}, mem_adr, v.exp_adr);
            if (v.exp_we) chk({v.name, " wdata"}, mem_wdata, v.exp_wdata);
          end
          mem_ready = (acc == v.k);
          mem_rdata = mem_ready ? v.rdata : 32'h0BAD0BAD;
        end else begin
          mem_ready = 1'b0;
        end
        @(negedge clk);
      end else begin
        done = 1;
        chk({v.name, " stall_cycles"}, stall_n, v.exp_stall);
        chk({v.name, " req_seen"}, {31'b0, req_seen}, {31'b0, v.exp_req});
        chk({v.name, " fault"}, {31'b0, dmem_fault}, {31'b0, v.exp_fault});
        chk({v.name, " rdata"}, dmem_rdata, v.exp_rd);
        ex_opcode = NOP;
        mem_ready = 1'b0;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: no completion within 20 cycles", v.name);
      ex_opcode = NOP;
      mem_ready = 1'b0;
    end
    @(negedge clk);
    #1;
    chk({v.name, " fault_after"}, {31'b0, dmem_fault}, 32'h0);
    chk({v.name, " req_after"},   {31'b0, mem_req},    32'h0);
  endtask

  initial begin
    vecs[0]  = mk("LW",      LOAD,  3'b010, 32'h100, 32'h4, 0, 32'hDEADBEEF, 1, 1, 0, 4'b1111, 32'h104, 0, 32'hDEADBEEF, 0, 2);
    vecs[1]  = mk("LB",      LOAD,  3'b000, 32'h200, 32'h3, 0, 32'h80FF1234, 1, 1, 0, 4'b1111, 32'h200, 0, 32'hFFFFFF80, 0, 2);
    vecs[2]  = mk("LBU",     LOAD,  3'b100, 32'h200, 32'h3, 0, 32'h80FF1234, 2, 1, 0, 4'b1111, 32'h200, 0, 32'h00000080, 0, 3);
    vecs[3]  = mk("SH",      STORE, 3'b001, 32'h300, 32'h2, 32'h0000ABCD, 0, 3, 1, 1, 4'b1100, 32'h300, 32'hABCDABCD, 32'h00000080, 0, 4);
    vecs[4]  = mk("LW_mis",  LOAD,  3'b010, 32'h100, 32'h1, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0, 1, 1);
    vecs[5]  = mk("LH",      LOAD,  3'b001, 32'h400, 32'hFFFFFFFE, 0, 32'h80017777, 1, 1, 0, 4'b1111, 32'h3FC, 0, 32'hFFFF8001, 0, 2);
    vecs[6]  = mk("LHU",     LOAD,  3'b101, 32'h10, 32'h0, 0, 32'hAAAAFEDC, 1, 1, 0, 4'b1111, 32'h10, 0, 32'h0000FEDC, 0, 2);
    vecs[7]  = mk("SB",      STORE, 3'b000, 32'h500, 32'h1, 32'h123456A5, 0, 1, 1, 1, 4'b0010, 32'h500, 32'hA5A5A5A5, 32'h0000FEDC, 0, 2);
    vecs[8]  = mk("SW",      STORE, 3'b010, 32'h600, 32'h8, 32'hCAFEF00D, 0, 1, 1, 1, 4'b1111, 32'h608, 32'hCAFEF00D, 32'h0000FEDC, 0, 2);
    vecs[9]  = mk("LD_f3",   LOAD,  3'b011, 32'h700, 32'h0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0, 1, 1);
    vecs[10] = mk("LW2",     LOAD,  3'b010, 32'h0, 32'h20, 0, 32'h13579BDF, 1, 1, 0, 4'b1111, 32'h20, 0, 32'h13579BDF, 0, 2);
    vecs[11] = mk("ST_f3",   STORE, 3'b100, 32'h700, 32'h0, 32'h1, 0, 1, 0, 0, 0, 0, 0, 32'h0, 1, 1);
    vecs[12] = mk("SH_mis",  STORE, 3'b001, 32'h700, 32'h1, 32'h1, 0, 1, 0, 0, 0, 0, 0, 32'h0, 1, 1);
    vecs[13] = mk("LW3",     LOAD,  3'b010, 32'h0, 32'h24, 0, 32'h2468ACE0, 1, 1, 0, 4'b1111, 32'h24, 0, 32'h2468ACE0, 0, 2);

    resetn = 1'b0;
    ex_opcode = NOP; ex_funct3 = '0; ex_rs1 = '0; ex_immVal = '0; ex_rs2 = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    #3;
    chk("reset req",   {31'b0, mem_req},    32'h0);
    chk("reset we",    {31'b0, mem_we},     32'h0);
    chk("reset be",    {28'b0, mem_be},     32'h0);
    chk("reset adr",   mem_adr,             32'h0);
    chk("reset wdata", mem_wdata,           32'h0);
    chk("reset rdata", dmem_rdata,          32'h0);
    chk("reset fault", {31'b0, dmem_fault}, 32'h0);
    chk("reset stall", {31'b0, dmem_stall}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    for (int unsigned i = 0; i < 14; i++) run_vec(vecs[i]);

    // Non-memory op with a chattering ready line must stay inert.
    @(negedge clk);
    ex_opcode = ADD; ex_funct3 = 3'b000; ex_rs1 = 32'h40; ex_immVal = 32'h0;
    for (int c = 0; c < 6; c++) begin
      mem_ready = c[0];
      mem_rdata = 32'hFFFFFFFF;
      #1;
      chk($sformatf("ADD req c%0d", c),   {31'b0, mem_req},    32'h0);
      chk($sformatf("ADD stall c%0d", c), {31'b0, dmem_stall}, 32'h0);
      chk($sformatf("ADD rdata c%0d", c), dmem_rdata,          32'h2468ACE0);
      @(negedge clk);
    end
    mem_ready = 1'b0;
    ex_opcode = NOP;

    // Reset in the middle of an outstanding access.
    @(negedge clk);
    ex_opcode = LOAD; ex_funct3 = 3'b010; ex_rs1 = 32'h100; ex_immVal = 32'h4;
    @(negedge clk);
    #1;
    chk("rst_mid req_before", {31'b0, mem_req}, 32'h1);
    #1;
    resetn = 1'b0;
    #1;
    chk("rst_mid req",   {31'b0, mem_req},    32'h0);
    chk("rst_mid rdata", dmem_rdata,          32'h0);
    chk("rst_mid stall", {31'b0, dmem_stall}, 32'h1);
    ex_opcode = NOP;
    @(negedge clk);
    resetn = 1'b1;
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global timeout: bench did not complete");
    $fatal(1);
  end

endmodule
